uart_echo_engine: RTL and testbench

Parametrised buffered processing stage between `uart_rx` and `uart_tx`, replacing the single-slot echo register in the UART top level. It accepts received words into a FIFO and applies a selectable transform (pass, multiply, invert, bit-reverse). It then issues each result to the transmitter using a real busy handshake, so back-to-back received words are never lost while a transmission is in flight. It runs on the PLL fast clock alongside both UART cores.

---
 rtl/uart_echo_pkg.sv | 28 ++
 rtl/uart_echo_engine_if.sv | 21 ++
 rtl/uart_echo_engine_fifo.sv | 81 ++++++++
 rtl/uart_echo_engine.sv | 163 ++++++++++++++++
 tb/tb_uart_echo_engine.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types for the UART echo engine: transform modes, TX FSM states and
// the FIFO level-width helper.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_MULT    = 2'd1,
    MODE_INVERT  = 2'd2,
    MODE_REVERSE = 2'd3
  } echo_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  localparam int ECHO_DEFAULT_DEPTH = 32'sd16;

  // Occupancy needs one bit more than the pointers so "full" is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  localparam int ECHO_DEFAULT_LVL_W = level_w(ECHO_DEFAULT_DEPTH);

endpackage

// File: rtl/uart_echo_engine_if.sv
// Word-level handshake between the echo engine and the uart_rx/uart_tx cores.
// master = the echo engine, slave = the UART cores.
interface uart_echo_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output tx_data, tx_start
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  tx_data, tx_start
  );
endinterface

// File: rtl/uart_echo_engine_fifo.sv
// echo_fifo: synchronous FIFO with registered occupancy; the head word is
// presented combinationally on rdata, pointers wrap modulo FIFO_DEPTH.
module echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic [DATA_W-1:0]                wdata,
  output logic [DATA_W-1:0]                rdata,
  output logic                             full,
  output logic                             empty,
  output logic [level_w(FIFO_DEPTH)-1:0]   level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = level_w(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              wr_en_s;
  logic              rd_en_s;

  // Qualify requests: a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    if (pop && (level_r != LVL_ZERO)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    if (push && ((level_r != LVL_FULL) || rd_en_s)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage array; contents are discarded on reset by clearing the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= LVL_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + LVL_W'(1'b1);
        2'b01:   level_r <= level_r - LVL_W'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (level_r == LVL_FULL);
  assign empty = (level_r == LVL_ZERO);
  assign level = level_r;

endmodule

// File: rtl/uart_echo_engine.sv
// uart_echo_engine: transforms received words into a FIFO and issues them to
// uart_tx with a busy handshake. Optional counters: define UART_ECHO_STATS_EN.
module uart_echo_engine
  import uart_echo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MULT       = 2,
  parameter int BUSY_WAIT  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  uart_echo_if.master                    bus,
  input  logic [1:0]                     mode,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic                           overflow,
  input  logic                           clr_overflow
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [CNT_W-1:0]               rx_count,
  output logic [CNT_W-1:0]               tx_count
`endif
);

  localparam int WAIT_W = $clog2(BUSY_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);
  localparam logic [DATA_W-1:0] MULT_C    = DATA_W'(MULT);

  tx_state_e         state_r;
  tx_state_e         state_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [DATA_W-1:0] xform_s;
  logic [DATA_W-1:0] head_s;
  logic [DATA_W-1:0] tx_data_r;
  logic              tx_start_r;
  logic              overflow_r;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;

  // Multiply keeps only the low DATA_W bits since both operands are DATA_W wide.
  function automatic logic [DATA_W-1:0] xform(input logic [1:0] sel,
                                              input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (echo_mode_e'(sel))
      MODE_PASS:    r = d;
      MODE_MULT:    r = d * MULT_C;
      MODE_INVERT:  r = ~d;
      MODE_REVERSE: for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
      default:      r = d;
    endcase
    return r;
  endfunction

  echo_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (xform_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  // Transform at write time using the mode sampled with rx_valid.
  always_comb begin
    xform_s = xform(mode, bus.rx_data);
  end

  // TX FSM next state and pop; a full FIFO still accepts a push alongside a pop.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: state_s = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_s = ST_WAIT_DONE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    push_s = bus.rx_valid && (!fifo_full_s || pop_s);
    drop_s = bus.rx_valid && fifo_full_s && !pop_s;
  end

  // FSM state, busy-wait timer, registered TX outputs and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      tx_data_r  <= {DATA_W{1'b0}};
      tx_start_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      tx_start_r <= (state_s == ST_START);
      if (state_r == ST_WAIT_BUSY) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
      if (pop_s) begin
        tx_data_r <= head_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

`ifdef UART_ECHO_STATS_EN
  // Accepted-push and issued-word counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_count <= {CNT_W{1'b0}};
      tx_count <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        rx_count <= rx_count + CNT_W'(1'b1);
      end
      if (state_s == ST_START) begin
        tx_count <= tx_count + CNT_W'(1'b1);
      end
    end
  end
`endif

  assign bus.tx_data  = tx_data_r;
  assign bus.tx_start = tx_start_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench for uart_echo_engine with a simple uart_tx busy model.
module tb_uart_echo_engine;
  import uart_echo_pkg::*;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int LVL_W  = level_w(16);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mode;
  logic             clr_overflow;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
`ifdef UART_ECHO_STATS_EN
  logic [CNT_W-1:0] rx_count;
  logic [CNT_W-1:0] tx_count;
`endif
  logic busy_force;
  int   busy_len;
  int   busy_cnt;
  int   total = 0;
  int   bad   = 0;

  uart_echo_if #(.DATA_W(DATA_W)) ifc ();

  uart_echo_engine #(
    .DATA_W(DATA_W), .FIFO_DEPTH(16), .MULT(2), .BUSY_WAIT(4), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (ifc),
    .mode         (mode),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef UART_ECHO_STATS_EN
    ,
    .rx_count     (rx_count),
    .tx_count     (tx_count)
`endif
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for busy_len cycles starting the cycle after tx_start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (ifc.tx_start && busy_len > 0) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign ifc.tx_busy = busy_force || (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] d);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = d;
    mode         = m;
    step();
    ifc.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(dut.state_r == ST_IDLE && ifc.tx_busy == 1'b0) && n < 60) begin
      step();
      n++;
    end
    chk(tag, {31'd0, (dut.state_r == ST_IDLE) && (n < 60)}, 32'd1);
  endtask

  task automatic wait_start(input string tag, input logic [7:0] exp);
    int n = 0;
    step();
    while (ifc.tx_start !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    chk(tag, {23'd0, n < 80, ifc.tx_data}, {23'd0, 1'b1, exp});
  endtask

  task automatic xform_case(input string tag, input logic [1:0] m,
                            input logic [7:0] d, input logic [7:0] exp);
    send(m, d);
    chk({tag, "_lvl1"}, 32'(fifo_level), 32'd1);
    chk({tag, "_nostart_c1"}, 32'(ifc.tx_start), 32'd0);
    step();
    chk({tag, "_start_c2"}, 32'(ifc.tx_start), 32'd1);
    chk({tag, "_data"}, 32'(ifc.tx_data), 32'(exp));
    chk({tag, "_lvl0"}, 32'(fifo_level), 32'd0);
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int starts;
    int n;
    rst_n = 1'b0; mode = 2'd0; clr_overflow = 1'b0;
    ifc.rx_valid = 1'b0; ifc.rx_data = 8'h00;
    busy_force = 1'b0; busy_len = 10;
    repeat (3) step();
    chk("rst_tx_data", 32'(ifc.tx_data), 32'd0);
    chk("rst_tx_start", 32'(ifc.tx_start), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
    rst_n = 1'b1;
    step(); step();

    // Transforms; PASS uses a 10-cycle busy, the rest a short one.
    xform_case("pass", MODE_PASS, 8'h41, 8'h41);
    busy_len = 2;
    xform_case("mult", MODE_MULT, 8'h90, 8'h20);
    xform_case("invert", MODE_INVERT, 8'h0F, 8'hF0);
    xform_case("reverse", MODE_REVERSE, 8'h01, 8'h80);
`ifdef UART_ECHO_STATS_EN
    chk("stats_rx4", 32'(rx_count), 32'd4);
    chk("stats_tx4", 32'(tx_count), 32'd4);
`endif

    // 20 back-to-back words with tx_busy stuck high: 1 in flight, 16 stored, 3 dropped.
    busy_force = 1'b1; mode = MODE_PASS; ifc.rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ifc.rx_data = 8'(i + 1);
      step();
      if (i == 16) begin
        chk("fill_level16", 32'(fifo_level), 32'd16);
        chk("fill_no_ovf", 32'(overflow), 32'd0);
      end
    end
    ifc.rx_valid = 1'b0;
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_inflight", 32'(ifc.tx_data), 32'h01);
    busy_force = 1'b0;
    for (int i = 0; i < 16; i++) wait_start($sformatf("drain%0d", i), 8'(i + 2));
    wait_idle("drain_idle");
    chk("drain_level0", 32'(fifo_level), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO: push in the same cycle as the IDLE pop is accepted.
    busy_force = 1'b1; ifc.rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ifc.rx_data = 8'(8'h30 + i);
      step();
    end
    ifc.rx_valid = 1'b0;
    chk("full2_level", 32'(fifo_level), 32'd16);
    chk("full2_no_ovf", 32'(overflow), 32'd0);
    busy_force = 1'b0;
    n = 0;
    while (dut.state_r != ST_IDLE && n < 20) begin step(); n++; end
    chk("full2_idle", 32'(dut.state_r), 32'(ST_IDLE));
    send(MODE_PASS, 8'hAA);
    chk("simul_level16", 32'(fifo_level), 32'd16);
    chk("simul_no_ovf", 32'(overflow), 32'd0);
    chk("simul_start", {23'd0, ifc.tx_start, ifc.tx_data}, {23'd0, 1'b1, 8'h31});
    for (int i = 0; i < 15; i++) wait_start($sformatf("drain2_%0d", i), 8'(8'h32 + i));
    wait_start("drain2_aa", 8'hAA);
    wait_idle("drain2_idle");

    // Clear coincident with a drop: set wins.
    busy_force = 1'b1; ifc.rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ifc.rx_data = 8'(8'h50 + i);
      step();
    end
    clr_overflow = 1'b1; ifc.rx_data = 8'hEE;
    step();
    clr_overflow = 1'b0; ifc.rx_valid = 1'b0;
    chk("clr_vs_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_vs_drop_lvl", 32'(fifo_level), 32'd16);
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    chk("clr_alone", 32'(overflow), 32'd0);

    // Reset while in WAIT_DONE with 5 words queued.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    ifc.rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ifc.rx_data = 8'(8'h60 + i);
      step();
    end
    ifc.rx_valid = 1'b0;
    chk("pre_rst_state", 32'(dut.state_r), 32'(ST_WAIT_DONE));
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    #2; rst_n = 1'b0; #1;
    chk("mid_rst_tx_data", 32'(ifc.tx_data), 32'd0);
    chk("mid_rst_tx_start", 32'(ifc.tx_start), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_state", 32'(dut.state_r), 32'(ST_IDLE));
`ifdef UART_ECHO_STATS_EN
    chk("mid_rst_rx_count", 32'(rx_count), 32'd0);
    chk("mid_rst_tx_count", 32'(tx_count), 32'd0);
`endif
    busy_force = 1'b0;
    step(); rst_n = 1'b1;
    starts = 0;
    repeat (10) begin
      step();
      if (ifc.tx_start === 1'b1) starts++;
    end
    chk("post_rst_no_start", 32'(starts), 32'd0);
    send(MODE_PASS, 8'h77);
    step();
    chk("post_rst_start", {23'd0, ifc.tx_start, ifc.tx_data}, {23'd0, 1'b1, 8'h77});
`ifdef UART_ECHO_STATS_EN
    chk("post_rst_rx_count", 32'(rx_count), 32'd1);
    chk("post_rst_tx_count", 32'(tx_count), 32'd1);
`endif
    wait_idle("post_rst_idle");

    // tx_busy never rises: 4 cycles in WAIT_BUSY, then the next word issues.
    busy_len = 0;
    ifc.rx_valid = 1'b1; ifc.rx_data = 8'h11; step();
    ifc.rx_data = 8'h22; step();
    ifc.rx_valid = 1'b0;
    chk("tmo_start1", {23'd0, ifc.tx_start, ifc.tx_data}, {23'd0, 1'b1, 8'h11});
    repeat (4) step();
    chk("tmo_still_waiting", 32'(dut.state_r), 32'(ST_WAIT_BUSY));
    step();
    chk("tmo_idle", 32'(dut.state_r), 32'(ST_IDLE));
    chk("tmo_no_start", 32'(ifc.tx_start), 32'd0);
    step();
    chk("tmo_start2", {23'd0, ifc.tx_start, ifc.tx_data}, {23'd0, 1'b1, 8'h22});
    wait_idle("tmo_final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
